// File: rtl/apb_gpio_n_if.sv
// apb_gpio_n_if: APB slave bus bundle for the GPIO block.
//   PSEL/PENABLE/PWRITE : transfer control (master -> slave)
//   PADDR[7:0]          : byte address
//   PWDATA[31:0]        : write data
//   PRDATA[31:0]        : read data (slave -> master)
//   PREADY / PSLVERR    : transfer ready / error (slave -> master)
interface apb_gpio_n_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PSLVERR);
    modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_gpio_n.sv
// apb_gpio_n: APB GPIO block with synchronised, debounced inputs and per-pin interrupts.
//   PCLK, PRESETn     : clock, asynchronous active-low reset
//   apb               : APB slave bus (zero wait states, PREADY tied high)
//   gpio_in_raw       : asynchronous pad inputs
//   gpio_out/gpio_oe  : output data / output enable straight from OUT / DIR
//   gpio_irq          : level interrupt, OR of INT_STATUS & INT_MASK
// Optional macro GPIO_ATOMIC_OUT_EN adds write-only OUT_SET/OUT_CLR/OUT_TGL at 0x24/0x28/0x2C.
module apb_gpio_n #(
    parameter int WIDTH    = 32,
    parameter int DB_CNT_W = 8
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    apb_gpio_n_if.slave      apb,
    input  logic [WIDTH-1:0] gpio_in_raw,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             gpio_irq
);
    localparam logic [7:0] A_DIR  = 8'h00;
    localparam logic [7:0] A_OUT  = 8'h04;
    localparam logic [7:0] A_IN   = 8'h08;
    localparam logic [7:0] A_MASK = 8'h0C;
    localparam logic [7:0] A_STS  = 8'h10;
    localparam logic [7:0] A_TYPE = 8'h14;
    localparam logic [7:0] A_POL  = 8'h18;
    localparam logic [7:0] A_DB   = 8'h1C;
    localparam logic [7:0] A_BOTH = 8'h20;
    localparam logic [7:0] A_RAW  = 8'h30;
`ifdef GPIO_ATOMIC_OUT_EN
    localparam logic [7:0] A_SET  = 8'h24;
    localparam logic [7:0] A_CLR  = 8'h28;
    localparam logic [7:0] A_TGL  = 8'h2C;
`endif
    localparam logic [DB_CNT_W-1:0] ONE = DB_CNT_W'(1);

    logic [WIDTH-1:0]    r_dir, r_out, r_mask, r_status, r_type, r_pol, r_both, r_raw;
    logic [WIDTH-1:0]    r_sync1, r_sync2, r_deb, r_deb_d;
    logic [DB_CNT_W-1:0] r_dbcfg;
    logic [DB_CNT_W-1:0] r_cnt [WIDTH];

    logic                w_acc, w_we, w_rd_ok, w_wr_ok, w_atom, w_cfg_wr;
    logic [WIDTH-1:0]    w_wd, w_w1c, w_rise, w_fall, w_edge, w_lvl, w_ev;
    logic [31:0]         w_rdata;
    logic                w_unused;

    assign w_unused = ^apb.PWDATA;
    assign w_wd     = apb.PWDATA[WIDTH-1:0];
    assign w_acc    = apb.PSEL & apb.PENABLE;

`ifdef GPIO_ATOMIC_OUT_EN
    assign w_atom = apb.PADDR inside {A_SET, A_CLR, A_TGL};
`else
    assign w_atom = 1'b0;
`endif

    assign w_wr_ok  = (apb.PADDR inside {A_DIR, A_OUT, A_MASK, A_STS, A_TYPE, A_POL, A_DB, A_BOTH}) | w_atom;
    assign w_rd_ok  = (apb.PADDR inside {A_DIR, A_OUT, A_IN, A_MASK, A_STS, A_TYPE, A_POL, A_DB, A_BOTH, A_RAW}) | w_atom;
    assign w_we     = w_acc & apb.PWRITE & w_wr_ok;
    assign w_cfg_wr = w_we & (apb.PADDR == A_DB);
    assign w_w1c    = (w_we && apb.PADDR == A_STS) ? w_wd : '0;

    // Event detection works on the debounced value and its one-cycle delayed copy.
    assign w_rise = r_deb & ~r_deb_d;
    assign w_fall = ~r_deb & r_deb_d;
    assign w_edge = (r_both & (w_rise | w_fall)) | (~r_both & r_pol & w_rise) | (~r_both & ~r_pol & w_fall);
    assign w_lvl  = ~(r_deb ^ r_pol);
    assign w_ev   = (r_type & w_edge) | (~r_type & w_lvl);

    always_comb begin
        w_rdata = '0;
        case (apb.PADDR)
            A_DIR:   w_rdata = 32'(r_dir);
            A_OUT:   w_rdata = 32'(r_out);
            A_IN:    w_rdata = 32'(r_deb);
            A_MASK:  w_rdata = 32'(r_mask);
            A_STS:   w_rdata = 32'(r_status);
            A_TYPE:  w_rdata = 32'(r_type);
            A_POL:   w_rdata = 32'(r_pol);
            A_DB:    w_rdata = 32'(r_dbcfg);
            A_BOTH:  w_rdata = 32'(r_both);
            A_RAW:   w_rdata = 32'(r_raw);
            default: w_rdata = '0;
        endcase
    end

    assign apb.PREADY  = 1'b1;
    assign apb.PRDATA  = (w_acc & ~apb.PWRITE & w_rd_ok) ? w_rdata : '0;
    assign apb.PSLVERR = PRESETn & w_acc & (apb.PWRITE ? ~w_wr_ok : ~w_rd_ok);

    assign gpio_out = r_out;
    assign gpio_oe  = r_dir;
    assign gpio_irq = |(r_status & r_mask);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_dir    <= '0;
            r_out    <= '0;
            r_mask   <= '0;
            r_status <= '0;
            r_type   <= '0;
            r_pol    <= '0;
            r_both   <= '0;
            r_raw    <= '0;
            r_dbcfg  <= '0;
        end else begin
            if (w_we && apb.PADDR == A_DIR)  r_dir  <= w_wd;
            if (w_we && apb.PADDR == A_MASK) r_mask <= w_wd;
            if (w_we && apb.PADDR == A_TYPE) r_type <= w_wd;
            if (w_we && apb.PADDR == A_POL)  r_pol  <= w_wd;
            if (w_we && apb.PADDR == A_BOTH) r_both <= w_wd;
            if (w_cfg_wr)                    r_dbcfg <= apb.PWDATA[DB_CNT_W-1:0];
`ifdef GPIO_ATOMIC_OUT_EN
            if (w_we)
                r_out <= (apb.PADDR == A_OUT) ? w_wd :
                         (apb.PADDR == A_SET) ? (r_out | w_wd) :
                         (apb.PADDR == A_CLR) ? (r_out & ~w_wd) :
                         (apb.PADDR == A_TGL) ? (r_out ^ w_wd) : r_out;
`else
            if (w_we && apb.PADDR == A_OUT)  r_out <= w_wd;
`endif
            r_raw    <= w_ev;
            // A new event sets the bit even when the same write clears it.
            r_status <= (r_status & ~w_w1c) | (w_ev & r_mask);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_deb_d <= '0;
            for (int k = 0; k < WIDTH; k++) r_cnt[k] <= '0;
        end else begin
            r_sync1 <= gpio_in_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            for (int k = 0; k < WIDTH; k++) begin
                // A config write restarts every count but keeps the debounced value.
                if (w_cfg_wr)
                    r_cnt[k] <= '0;
                else if (r_dbcfg == '0)
                    r_deb[k] <= r_sync2[k];
                else if (r_sync2[k] == r_deb[k])
                    r_cnt[k] <= '0;
                else if (r_cnt[k] + ONE == r_dbcfg) begin
                    r_deb[k] <= r_sync2[k];
                    r_cnt[k] <= '0;
                end else
                    r_cnt[k] <= r_cnt[k] + ONE;
            end
        end
    end
endmodule

// File: tb/tb_apb_gpio_n.sv
// tb_apb_gpio_n: randomized and directed bench for apb_gpio_n (WIDTH=8) against a behavioural model.
module tb_apb_gpio_n;
    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic [7:0] raw = '0;
    logic [7:0] gpio_out, gpio_oe;
    logic       gpio_irq;
    int         checks = 0;
    int         failures = 0;

    apb_gpio_n_if bus();

    apb_gpio_n #(.WIDTH(8), .DB_CNT_W(8)) dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .apb         (bus),
        .gpio_in_raw (raw),
        .gpio_out    (gpio_out),
        .gpio_oe     (gpio_oe),
        .gpio_irq    (gpio_irq)
    );

    always #5 PCLK = ~PCLK;

    // Behavioural model state
    logic [7:0] m_dir, m_out, m_mask, m_sts, m_type, m_pol, m_both, m_raw, m_deb, m_debd;
    logic [7:0] m_hist [2];
    int         m_n;
    int         m_run [8];

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_dir = '0; m_out = '0; m_mask = '0; m_sts = '0; m_type = '0; m_pol = '0;
        m_both = '0; m_raw = '0; m_deb = '0; m_debd = '0; m_n = 0;
        m_hist[0] = '0; m_hist[1] = '0;
        for (int i = 0; i < 8; i++) m_run[i] = 0;
    endfunction

    function automatic bit rd_ok(logic [7:0] a);
        int unsigned v = a;
`ifdef GPIO_ATOMIC_OUT_EN
        if (v == 'h24 || v == 'h28 || v == 'h2C) return 1;
`endif
        return (v <= 'h20 && v % 4 == 0) || v == 'h30;
    endfunction

    function automatic bit wr_ok(logic [7:0] a);
        return rd_ok(a) && a != 8'h08 && a != 8'h30;
    endfunction

    function automatic logic [31:0] exp_prdata();
        if (!(bus.PSEL && bus.PENABLE) || bus.PWRITE) return 0;
        case (bus.PADDR)
            8'h00: return {24'h0, m_dir};
            8'h04: return {24'h0, m_out};
            8'h08: return {24'h0, m_deb};
            8'h0C: return {24'h0, m_mask};
            8'h10: return {24'h0, m_sts};
            8'h14: return {24'h0, m_type};
            8'h18: return {24'h0, m_pol};
            8'h1C: return m_n;
            8'h20: return {24'h0, m_both};
            8'h30: return {24'h0, m_raw};
            default: return 0;
        endcase
    endfunction

    function automatic logic exp_err();
        if (!PRESETn || !(bus.PSEL && bus.PENABLE)) return 0;
        return bus.PWRITE ? !wr_ok(bus.PADDR) : !rd_ok(bus.PADDR);
    endfunction

    // Advance the model by one rising edge using the pre-edge inputs.
    function automatic void model_step();
        logic [7:0]  ev, sync, nd, w1c;
        logic [7:0]  a;
        logic [31:0] d;
        bit          wr;
        if (!PRESETn) begin
            model_reset();
            return;
        end
        wr = bus.PSEL && bus.PENABLE && bus.PWRITE && wr_ok(bus.PADDR);
        a  = bus.PADDR;
        d  = bus.PWDATA;
        for (int i = 0; i < 8; i++)
            if (m_type[i]) ev[i] = (m_deb[i] != m_debd[i]) && (m_both[i] || m_deb[i] == m_pol[i]);
            else           ev[i] = (m_deb[i] == m_pol[i]);
        sync = m_hist[1];
        nd   = m_deb;
        for (int i = 0; i < 8; i++) begin
            if (wr && a == 8'h1C) m_run[i] = 0;
            else if (m_n == 0) nd[i] = sync[i];
            else if (sync[i] == m_deb[i]) m_run[i] = 0;
            else begin
                m_run[i]++;
                if (m_run[i] >= m_n) begin
                    nd[i] = sync[i];
                    m_run[i] = 0;
                end
            end
        end
        m_hist[1] = m_hist[0];
        m_hist[0] = raw;
        m_debd = m_deb;
        m_deb  = nd;
        m_raw  = ev;
        w1c    = (wr && a == 8'h10) ? d[7:0] : 8'h00;
        m_sts  = (m_sts & ~w1c) | (ev & m_mask);
        if (wr)
            case (a)
                8'h00: m_dir  = d[7:0];
                8'h04: m_out  = d[7:0];
                8'h0C: m_mask = d[7:0];
                8'h14: m_type = d[7:0];
                8'h18: m_pol  = d[7:0];
                8'h1C: m_n    = d[7:0];
                8'h20: m_both = d[7:0];
`ifdef GPIO_ATOMIC_OUT_EN
                8'h24: m_out  = m_out | d[7:0];
                8'h28: m_out  = m_out & ~d[7:0];
                8'h2C: m_out  = m_out ^ d[7:0];
`endif
                default: ;
            endcase
    endfunction

    // Continuous comparison of every observable output against the model.
    always @(negedge PCLK) begin
        chk("oe", {24'h0, gpio_oe}, {24'h0, m_dir});
        chk("out", {24'h0, gpio_out}, {24'h0, m_out});
        chk("irq", {31'h0, gpio_irq}, {31'h0, |(m_sts & m_mask)});
        chk("pready", {31'h0, bus.PREADY}, 32'h1);
        chk("pslverr", {31'h0, bus.PSLVERR}, {31'h0, exp_err()});
        chk("prdata", bus.PRDATA, exp_prdata());
    end

    task automatic tick();
        @(posedge PCLK);
        model_step();
        #1;
    endtask

    task automatic xfer(input bit w, input logic [7:0] a, input logic [31:0] d,
                        output logic [31:0] rdata, output logic err);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = w; bus.PADDR = a; bus.PWDATA = d;
        tick();
        bus.PENABLE = 1'b1;
        @(negedge PCLK);
        rdata = bus.PRDATA;
        err   = bus.PSLVERR;
        tick();
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] r;
        logic e;
        xfer(1'b1, a, d, r, e);
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] r);
        logic e;
        xfer(1'b0, a, d_zero(), r, e);
    endtask

    function automatic logic [31:0] d_zero();
        return 32'h0;
    endfunction

    initial begin
        logic [31:0] r;
        logic        e;
        int          n, mn;
        bit          seen;
        logic [7:0]  addrs [16] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                                    8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'h40, 8'h01, 8'hFC};
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
        model_reset();
        repeat (3) tick();
        chk("rst_out", {24'h0, gpio_out}, 32'h0);
        chk("rst_oe", {24'h0, gpio_oe}, 32'h0);
        chk("rst_irq", {31'h0, gpio_irq}, 32'h0);
        chk("rst_slverr", {31'h0, bus.PSLVERR}, 32'h0);
        PRESETn = 1'b1;
        repeat (2) tick();
        rd(8'h30, r);
        chk("raw_level_low", r, 32'h0000_00FF);
        wr(8'h14, 32'hFF);
        repeat (4) tick();
        rd(8'h30, r);
        chk("no_spurious_edge", r, 32'h0);

        wr(8'h00, 32'hFFFF_FF0F);
        wr(8'h04, 32'hA5);
        chk("dir_oe", {24'h0, gpio_oe}, 32'h0F);
        chk("out_val", {24'h0, gpio_out}, 32'hA5);
        rd(8'h00, r);
        chk("dir_read", r, 32'h0000_000F);

        wr(8'h1C, 32'h0000_0004);
        for (int p = 1; p <= 3; p++) begin
            raw[0] = 1'b1;
            repeat (p) tick();
            raw[0] = 1'b0;
            repeat (10) tick();
            rd(8'h08, r);
            chk("db_pulse_rejected", r, 32'h0);
        end
        bus.PSEL = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = 8'h08; bus.PENABLE = 1'b0;
        tick();
        bus.PENABLE = 1'b1;
        raw[0] = 1'b1;
        n = 0; mn = 0; seen = 0;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (m_deb[0] && mn == 0) mn = n;
            @(negedge PCLK);
            if (bus.PRDATA[0]) seen = 1;
        end
        chk("db_latency_in_range", {31'h0, seen && n >= 5 && n <= 7}, 32'h1);
        chk("model_db_latency", mn, 6);
        repeat (4) tick();
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        rd(8'h08, r);
        chk("db_held_high", r, 32'h1);

        wr(8'h1C, 32'h0);
        raw[0] = 1'b0;
        repeat (6) tick();
        wr(8'h20, 32'h1);
        wr(8'h10, 32'hFF);
        wr(8'h0C, 32'h1);
        raw[0] = 1'b1;
        repeat (5) tick();
        rd(8'h10, r);
        chk("both_rise_sts", r, 32'h1);
        chk("both_rise_irq", {31'h0, gpio_irq}, 32'h1);
        wr(8'h10, 32'h1);
        rd(8'h10, r);
        chk("both_w1c_sts", r, 32'h0);
        chk("both_w1c_irq", {31'h0, gpio_irq}, 32'h0);
        raw[0] = 1'b0;
        repeat (5) tick();
        rd(8'h10, r);
        chk("both_fall_sts", r, 32'h1);
        chk("both_fall_irq", {31'h0, gpio_irq}, 32'h1);
        wr(8'h10, 32'h1);
        rd(8'h10, r);
        chk("both_w1c2_sts", r, 32'h0);

        wr(8'h14, 32'h0);
        wr(8'h18, 32'h1);
        raw[0] = 1'b1;
        repeat (5) tick();
        wr(8'h10, 32'h1);
        rd(8'h10, r);
        chk("level_w1c_kept", r, 32'h1);
        raw[0] = 1'b0;
        repeat (5) tick();
        wr(8'h10, 32'h1);
        rd(8'h10, r);
        chk("level_cleared", r, 32'h0);
        chk("level_irq_off", {31'h0, gpio_irq}, 32'h0);
        raw[0] = 1'b1;
        repeat (5) tick();
        chk("mask_irq_on", {31'h0, gpio_irq}, 32'h1);
        wr(8'h0C, 32'h0);
        chk("mask_irq_off", {31'h0, gpio_irq}, 32'h0);
        rd(8'h10, r);
        chk("mask_sts_kept", r, 32'h1);
        raw[0] = 1'b0;
        repeat (4) tick();

        xfer(1'b0, 8'h40, 32'h0, r, e);
        chk("unmapped_rd_err", {31'h0, e}, 32'h1);
        chk("unmapped_rd_data", r, 32'h0);
        xfer(1'b1, 8'h08, 32'hFF, r, e);
        chk("ro_wr_err", {31'h0, e}, 32'h1);
        rd(8'h08, r);
        chk("ro_wr_in_kept", r, 32'h0);
        rd(8'h04, r);
        chk("ro_wr_out_kept", r, 32'hA5);

`ifdef GPIO_ATOMIC_OUT_EN
        wr(8'h04, 32'hF0);
        wr(8'h24, 32'h0F);
        wr(8'h28, 32'h81);
        xfer(1'b1, 8'h2C, 32'hFF, r, e);
        chk("tgl_no_err", {31'h0, e}, 32'h0);
        chk("atomic_out", {24'h0, gpio_out}, 32'h81);
        xfer(1'b0, 8'h24, 32'h0, r, e);
        chk("set_reads_zero", r, 32'h0);
`else
        xfer(1'b1, 8'h24, 32'h0F, r, e);
        chk("set_unmapped_err", {31'h0, e}, 32'h1);
        chk("set_unmapped_out", {24'h0, gpio_out}, 32'hA5);
`endif

        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 8'h04; bus.PWDATA = 32'h55;
        tick();
        bus.PENABLE = 1'b1;
        #2;
        PRESETn = 1'b0;
        model_reset();
        tick();
        chk("midreset_out", {24'h0, gpio_out}, 32'h0);
        PRESETn = 1'b1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        tick();
        chk("midreset_after", {24'h0, gpio_out}, 32'h0);

        for (int it = 0; it < 2500; it++) begin
            int unsigned sel;
            logic [7:0]  a;
            logic [31:0] d;
            if ($urandom_range(0, 5) == 0) raw[$urandom_range(0, 7)] ^= 1'b1;
            sel = $urandom_range(0, 9);
            a   = addrs[$urandom_range(0, 15)];
            d   = $urandom;
            if (a == 8'h1C) d = (d & 32'hFFFF_FF00) | $urandom_range(0, 3);
            if (sel < 3) xfer(1'b1, a, d, r, e);
            else if (sel < 6) xfer(1'b0, a, 32'h0, r, e);
            else tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/apb_gpio_n.md
APB_GPIO_N -- requirements
Module: apb_gpio_n

Interface
REQ-001 Parameter: WIDTH, default 32, number of GPIO pins; legal range 1..32.
REQ-002 Parameter: DB_CNT_W, default 8, debounce counter width; legal range 1..16.
REQ-003 Port: PCLK  in  1  single clock; all state on rising edge.
REQ-004 Port: PRESETn  in  1  reset, asynchronous assert, active-low.
REQ-005 Ports: PSEL, PENABLE, PWRITE  in  1 each  APB control.
REQ-006 Ports: PADDR in 8, byte address; PWDATA in 32, write data; PRDATA out 32, read data.
REQ-007 Ports: PREADY out 1, transfer ready; PSLVERR out 1, transfer error.
REQ-008 Port: gpio_in_raw  in  WIDTH  asynchronous pad inputs.
REQ-009 Ports: gpio_out out WIDTH, output data; gpio_oe out WIDTH, output enable (1 = drive).
REQ-010 Port: gpio_irq  out  1  level interrupt request.

Function
REQ-011 PREADY SHALL be constant 1; every transfer completes in its access phase, with no wait states.
REQ-012 Writes SHALL commit on the PCLK edge where PSEL & PENABLE & PWRITE = 1; PRDATA SHALL be valid combinationally in the access phase and 0 otherwise.
REQ-013 Register map: 0x00 DIR, 0x04 OUT, 0x08 IN (RO), 0x0C INT_MASK, 0x10 INT_STATUS (W1C), 0x14 INT_TYPE (1 = edge, 0 = level), 0x18 INT_POLARITY (1 = rising/high), 0x1C DEBOUNCE_CFG, 0x20 INT_BOTH, 0x30 INT_RAW (RO).
REQ-014 Register bits [31:WIDTH] and DEBOUNCE_CFG bits [31:DB_CNT_W] SHALL ignore writes and read 0.
REQ-015 Unmapped addresses and writes to RO registers SHALL assert PSLVERR in the access phase; no state changes; PRDATA = 0.
REQ-016 gpio_oe = DIR and gpio_out = OUT, both direct from registers with no added latency.
REQ-017 Each input SHALL pass a 2-flop synchroniser, then a per-pin debouncer, producing deb[i]; IN reads deb.
REQ-018 Debouncer, N = DEBOUNCE_CFG: the counter clears when sync == deb and increments otherwise; deb takes sync on the Nth consecutive mismatched sample, and the counter clears.
REQ-019 N = 0 SHALL bypass debounce: deb follows sync with 1 cycle of delay.
REQ-020 Writing DEBOUNCE_CFG SHALL clear all debounce counters; deb values are held.
REQ-021 Edge event on pin i when INT_TYPE[i] = 1, from deb versus its 1-cycle delayed copy:
- INT_BOTH[i] = 1: either edge.
- INT_BOTH[i] = 0: rising edge if INT_POLARITY[i] = 1, falling edge if 0.
REQ-022 Level event when INT_TYPE[i] = 0: asserted every cycle that deb[i] == INT_POLARITY[i]; INT_BOTH is ignored.
REQ-023 INT_RAW[i] SHALL be the registered, unmasked event. INT_STATUS[i] SHALL set when the event occurs and INT_MASK[i] = 1, and stay set until cleared.
REQ-024 W1C on INT_STATUS clears the written-1 bits; a same-cycle event SHALL win, so the bit remains set.
REQ-025 gpio_irq = OR(INT_STATUS & INT_MASK); clearing a mask bit SHALL deassert its contribution without clearing its status.

Reset
REQ-026 While PRESETn = 0: all registers, synchronisers, debounce counters, deb and its delayed copy SHALL be 0; gpio_out = 0, gpio_oe = 0, gpio_irq = 0, PSLVERR = 0.
REQ-027 A reset mid-transfer SHALL abort the transfer; the write has no effect.
REQ-028 No spurious edge event SHALL occur in the first cycles after reset release while inputs are held at 0.

Configuration
REQ-029 Macro GPIO_ATOMIC_OUT_EN defined: adds 0x24 OUT_SET (OUT |= wdata), 0x28 OUT_CLR (OUT &= ~wdata) and 0x2C OUT_TGL (OUT ^= wdata); all three are write-only and read 0 without error.
REQ-030 GPIO_ATOMIC_OUT_EN undefined: 0x24/0x28/0x2C are unmapped (PSLVERR per REQ-015), and no related logic is synthesised.

Verification
REQ-031 WIDTH=8: write DIR=0xFFFF_FF0F, OUT=0xA5 -> gpio_oe=0x0F, gpio_out=0xA5, DIR read returns 0x0000_000F.
REQ-032 DEBOUNCE_CFG=4; pin0 pulses of 1/2/3 cycles -> IN[0]=0; pin0 held high 8 cycles -> IN[0]=1, first seen 2+4 cycles after the edge (±1).
REQ-033 Pin0 INT_TYPE=1, INT_BOTH=1, mask=1; rise, W1C, fall -> INT_STATUS[0]=1 and gpio_irq=1 after each edge, 0 after each W1C.
REQ-034 Pin0 level-high, mask=1, input held 1; W1C 0x1 -> status stays 1; input 0 then W1C -> status 0, gpio_irq=0.
REQ-035 Read 0x40 and write 0x08 -> PSLVERR=1, register contents unchanged.
REQ-036 With GPIO_ATOMIC_OUT_EN: OUT=0xF0; SET 0x0F; CLR 0x81; TGL 0xFF -> OUT=0x81. Without the macro: write 0x24 -> PSLVERR=1.
